// File: rtl/dsfq_and_pulse_sequencer.sv
// Pulse sequencer for a single DSFQ_AND cell: fires skewed a/b pulses, watches q in a
// detection window, reports against the storage-window rule, then enforces a recovery gap.
module dsfq_and_pulse_sequencer #(
  parameter int unsigned SKEW_W   = 4,
  parameter int unsigned HOLD_CYC = 5,
  parameter int unsigned WIN_CYC  = 8,
  parameter int unsigned REC_CYC  = 6,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              req_order,
  input  logic [SKEW_W-1:0] req_skew,
  output logic              and_a,
  output logic              and_b,
  input  logic              and_q,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_exp,
  output logic              rsp_obs,
  output logic              rsp_match,
  output logic              rsp_multi,
  output logic              err_spurious,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam int unsigned SKEW_MAX = (32'(1) << SKEW_W) - 32'(1);
  localparam int unsigned TMR_MAX  = (SKEW_MAX > WIN_CYC)
                                   ? ((SKEW_MAX > REC_CYC) ? SKEW_MAX : REC_CYC)
                                   : ((WIN_CYC > REC_CYC) ? WIN_CYC : REC_CYC);
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE1, S_WAIT_SKEW, S_FIRE2, S_WAIT_Q, S_REPORT, S_RECOVER
  } state_t;

  state_t              r_state, w_state;
  logic [TMR_W-1:0]    r_tmr, w_tmr;
  logic                r_a, w_a, r_b, w_b, r_order, w_order;
  logic [SKEW_W-1:0]   r_skew, w_skew;
  logic                r_and_a, w_and_a, r_and_b, w_and_b;
  logic                r_req_ready, w_req_ready, r_busy, w_busy;
  logic                r_rsp_valid, w_rsp_valid;
  logic                r_exp, w_exp, r_obs, w_obs, r_match, w_match, r_multi, w_multi;
  logic                r_err, w_err;
  logic [CNT_W-1:0]    r_op_count, w_op_count;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_state     = r_state;
    w_tmr       = r_tmr;
    w_a         = r_a;
    w_b         = r_b;
    w_order     = r_order;
    w_skew      = r_skew;
    w_and_a     = 1'b0;
    w_and_b     = 1'b0;
    w_exp       = r_exp;
    w_obs       = r_obs;
    w_multi     = r_multi;
    w_op_count  = r_op_count;
    w_err       = r_err | (and_q & (r_state != S_WAIT_Q));

    case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state = S_FIRE1;
          w_a     = req_a;
          w_b     = req_b;
          w_order = req_order;
          w_skew  = req_skew;
          w_exp   = req_a & req_b & (32'(req_skew) <= HOLD_CYC);
          w_obs   = 1'b0;
          w_multi = 1'b0;
          w_and_a = req_a & (~req_order | (req_skew == '0));
          w_and_b = req_b & (req_order | (req_skew == '0));
        end
      end
      S_FIRE1: begin
        if (r_skew == '0) begin
          w_state = S_WAIT_Q;
          w_tmr   = TMR_W'(WIN_CYC - 1);
        end else if (r_skew == SKEW_W'(1)) begin
          w_state = S_FIRE2;
          w_and_a = r_a & r_order;
          w_and_b = r_b & ~r_order;
        end else begin
          w_state = S_WAIT_SKEW;
          w_tmr   = TMR_W'(r_skew) - TMR_W'(2);
        end
      end
      S_WAIT_SKEW: begin
        if (r_tmr == '0) begin
          w_state = S_FIRE2;
          w_and_a = r_a & r_order;
          w_and_b = r_b & ~r_order;
        end else begin
          w_tmr = r_tmr - TMR_W'(1);
        end
      end
      S_FIRE2: begin
        w_state = S_WAIT_Q;
        w_tmr   = TMR_W'(WIN_CYC - 1);
      end
      S_WAIT_Q: begin
        // First q marks observation, any later q in the same window marks multi.
        if (and_q) begin
          if (r_obs) w_multi = 1'b1;
          else       w_obs   = 1'b1;
        end
        if (r_tmr == '0) w_state = S_REPORT;
        else             w_tmr   = r_tmr - TMR_W'(1);
      end
      S_REPORT: begin
        if (rsp_ready && r_rsp_valid) begin
          w_op_count = r_op_count + CNT_W'(1);
          if (REC_CYC == 0) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_RECOVER;
            w_tmr   = TMR_W'(REC_CYC - 1);
          end
        end
      end
      S_RECOVER: begin
        if (r_tmr == '0) w_state = S_IDLE;
        else             w_tmr   = r_tmr - TMR_W'(1);
      end
      default: w_state = S_IDLE;
    endcase

    w_req_ready = (w_state == S_IDLE);
    w_busy      = (w_state != S_IDLE);
    w_rsp_valid = (w_state == S_REPORT);
    w_match     = (w_exp == w_obs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_order     <= 1'b0;
      r_skew      <= '0;
      r_and_a     <= 1'b0;
      r_and_b     <= 1'b0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_exp       <= 1'b0;
      r_obs       <= 1'b0;
      r_match     <= 1'b0;
      r_multi     <= 1'b0;
      r_err       <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_state     <= w_state;
      r_tmr       <= w_tmr;
      r_a         <= w_a;
      r_b         <= w_b;
      r_order     <= w_order;
      r_skew      <= w_skew;
      r_and_a     <= w_and_a;
      r_and_b     <= w_and_b;
      r_req_ready <= w_req_ready;
      r_busy      <= w_busy;
      r_rsp_valid <= w_rsp_valid;
      r_exp       <= w_exp;
      r_obs       <= w_obs;
      r_match     <= w_match;
      r_multi     <= w_multi;
      r_err       <= w_err;
      r_op_count  <= w_op_count;
    end
  end

  assign req_ready    = r_req_ready;
  assign and_a        = r_and_a;
  assign and_b        = r_and_b;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_exp      = r_exp;
  assign rsp_obs      = r_obs;
  assign rsp_match    = r_match;
  assign rsp_multi    = r_multi;
  assign err_spurious = r_err;
  assign busy         = r_busy;
  assign op_count     = r_op_count;

endmodule
